// File: rtl/keypad_pkg.sv
// Shared types and the key map for the multi-tap keypad encoder.
// Provides key classification, token layout and the 4x3 key table lookup.
package keypad_pkg;

  // Width of a flattened key index (row * COLS + col).
  localparam int unsigned KeyW = 8;

  typedef enum logic [2:0] {
    KindNone,
    KindLetter,
    KindSubmitLetter,
    KindSubmitWord,
    KindClear
  } key_kind_e;

  typedef struct packed {
    key_kind_e   kind;
    logic [7:0]  base;
    logic [2:0]  size;
  } key_entry_t;

  // One output token: a letter (word=0) or a word-submit marker (word=1, ch=0).
  typedef struct packed {
    logic       word;
    logic [7:0] ch;
  } token_t;

  function automatic key_entry_t mk_entry(key_kind_e kind, logic [7:0] base, logic [2:0] size);
    key_entry_t e;
    e.kind = kind;
    e.base = base;
    e.size = size;
    return e;
  endfunction

  // Keys outside the 4x3 table classify as NONE.
  function automatic key_entry_t key_lookup(logic [KeyW-1:0] idx);
    case (idx)
      8'd0:    return mk_entry(KindLetter, 8'h41, 3'd3);  // ABC
      8'd1:    return mk_entry(KindLetter, 8'h44, 3'd3);  // DEF
      8'd2:    return mk_entry(KindLetter, 8'h47, 3'd3);  // GHI
      8'd3:    return mk_entry(KindLetter, 8'h4A, 3'd3);  // JKL
      8'd4:    return mk_entry(KindLetter, 8'h4D, 3'd3);  // MNO
      8'd5:    return mk_entry(KindLetter, 8'h50, 3'd4);  // PQRS
      8'd6:    return mk_entry(KindLetter, 8'h54, 3'd3);  // TUV
      8'd7:    return mk_entry(KindLetter, 8'h57, 3'd4);  // WXYZ
      8'd9:    return mk_entry(KindSubmitLetter, 8'h00, 3'd0);
      8'd10:   return mk_entry(KindClear, 8'h00, 3'd0);
      8'd11:   return mk_entry(KindSubmitWord, 8'h00, 3'd0);
      default: return mk_entry(KindNone, 8'h00, 3'd0);
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: row synchronizer, one-hot column rotation and debounce.
// Ports: clk_i/rst_i (async active-high), row_i raw rows, col_o column drive,
//        press_o one-cycle press pulse, key_o key index (row * COLS + col) valid with press_o.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 3,
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 2000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ROWS-1:0]   row_i,
  output logic [COLS-1:0]   col_o,
  output logic              press_o,
  output logic [KeyW-1:0]   key_o
);

  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ScanW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);

  logic [ROWS-1:0]  row_s1_q, row_s2_q, row_prev_q;
  logic [ColW-1:0]  col_q, col_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic             down_q, down_d;
  logic             press_q, press_d;
  logic [KeyW-1:0]  key_q, key_d;
  logic             same, stable, freeze;
  int unsigned      row_idx;

  always_comb begin
    same   = (row_s2_q == row_prev_q);
    // Pattern has now been observed for DEBOUNCE_CYCLES consecutive cycles.
    stable = same && (deb_cnt_q == DebW'(DEBOUNCE_CYCLES - 2));

    deb_cnt_d = deb_cnt_q;
    if (!same) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DebW'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    row_idx = 0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (row_s2_q[i]) row_idx = i;
    end

    down_d  = down_q;
    press_d = 1'b0;
    key_d   = key_q;
    if (stable) begin
      if (!down_q && (row_s2_q != '0)) begin
        // Ghost patterns still latch "down" so they must be released first.
        down_d = 1'b1;
        if ($onehot(row_s2_q)) begin
          press_d = 1'b1;
          key_d   = KeyW'(row_idx * COLS + int'(col_q));
        end
      end else if (down_q && (row_s2_q == '0)) begin
        down_d = 1'b0;
      end
    end

    // Hold the column while rows are in flight through the synchronizer or a key
    // is still considered down, so the latched column matches the sampled rows.
    freeze     = down_q || ((row_s1_q | row_s2_q) != '0);
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    if (freeze) begin
      scan_cnt_d = '0;
    end else if (scan_cnt_q == ScanW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      col_d      = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_s1_q   <= '0;
      row_s2_q   <= '0;
      row_prev_q <= '0;
      col_q      <= '0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      down_q     <= 1'b0;
      press_q    <= 1'b0;
      key_q      <= '0;
    end else begin
      row_s1_q   <= row_i;
      row_s2_q   <= row_s1_q;
      row_prev_q <= row_s2_q;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      down_q     <= down_d;
      press_q    <= press_d;
      key_q      <= key_d;
    end
  end

  assign col_o   = COLS'(1) << col_q;
  assign press_o = press_q;
  assign key_o   = key_q;

endmodule

// File: rtl/keypad_multitap_encoder.sv
// Phone-style multi-tap keypad encoder.
// Ports: clk/rst (async active-high), row_in raw rows, col_out column drive,
//        pending_char letter being tapped (0 if none), out_char/out_word/out_valid/out_ready
//        token channel fed from a 2-entry FIFO, error one-cycle pulse on a rejected action.
module keypad_multitap_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 3,
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 2000,
  parameter int unsigned TAP_TIMEOUT     = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [7:0]      pending_char,
  output logic [7:0]      out_char,
  output logic            out_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            error
);

  localparam int unsigned TmoW = $clog2(TAP_TIMEOUT + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  logic            press;
  logic [KeyW-1:0] press_key;

  keypad_scan_debounce #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scan (
    .clk_i   (clk),
    .rst_i   (rst),
    .row_i   (row_in),
    .col_o   (col_out),
    .press_o (press),
    .key_o   (press_key)
  );

  logic [0:0]      state_q, state_d;
  logic [KeyW-1:0] key_q, key_d;
  logic [2:0]      tap_q, tap_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  token_t [1:0]    mem_q, mem_d;
  logic [1:0]      count_q, count_d;

  key_entry_t hit, cur;
  logic [7:0] cur_char;
  logic       pop, push0, push1;
  token_t     tok0, tok1;
  int         free_slots;

  always_comb begin
    hit      = key_lookup(press_key);
    cur      = key_lookup(key_q);
    cur_char = cur.base + {5'b0, tap_q};
    pop      = (count_q != 2'd0) && out_ready;
    // Slots available this cycle, counting one freed by a simultaneous transfer.
    free_slots = 2 - int'(count_q) + (pop ? 1 : 0);

    state_d = state_q;
    key_d   = key_q;
    tap_d   = tap_q;
    err_d   = 1'b0;
    push0   = 1'b0;
    push1   = 1'b0;
    tok0    = '0;
    tok1    = '0;

    tmo_d = tmo_q;
    if (press) begin
      tmo_d = '0;
    end else if (tmo_q != TmoW'(TAP_TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (press) begin
      case (state_q)
        StIdle: begin
          case (hit.kind)
            KindLetter: begin
              state_d = StPend;
              key_d   = press_key;
              tap_d   = '0;
            end
            KindSubmitLetter: err_d = 1'b1;
            KindSubmitWord: begin
              if (free_slots >= 1) begin
                push0 = 1'b1;
                tok0  = '{word: 1'b1, ch: 8'h00};
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        StPend: begin
          case (hit.kind)
            KindLetter: begin
              if ((press_key == key_q) && (tmo_q != TmoW'(TAP_TIMEOUT))) begin
                tap_d = ((tap_q + 3'd1) == cur.size) ? 3'd0 : tap_q + 3'd1;
              end else begin
                key_d = press_key;
                tap_d = '0;
              end
            end
            KindSubmitLetter: begin
              if (free_slots >= 1) begin
                push0   = 1'b1;
                tok0    = '{word: 1'b0, ch: cur_char};
                state_d = StIdle;
              end else begin
                err_d = 1'b1;
              end
            end
            KindClear: state_d = StIdle;
            KindSubmitWord: begin
              // Letter and marker go in together or not at all.
              if (free_slots >= 2) begin
                push0   = 1'b1;
                tok0    = '{word: 1'b0, ch: cur_char};
                push1   = 1'b1;
                tok1    = '{word: 1'b1, ch: 8'h00};
                state_d = StIdle;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // Head-at-index-0 FIFO: pop shifts, pushes append behind the survivors.
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = '0;
      count_d  = count_q - 2'd1;
    end
    if (push0) begin
      if (count_d == 2'd0) mem_d[0] = tok0;
      else                 mem_d[1] = tok0;
      count_d = count_d + 2'd1;
    end
    if (push1) begin
      mem_d[1] = tok1;
      count_d  = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      tap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tap_q   <= tap_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign pending_char = (state_q == StPend) ? cur_char : 8'h00;
  assign out_valid    = (count_q != 2'd0);
  assign out_char     = mem_q[0].ch;
  assign out_word     = mem_q[0].word;
  assign error        = err_q;

endmodule

// File: tb/tb_keypad_multitap_encoder.sv
// Directed bench for keypad_multitap_encoder with a behavioural key-matrix model.
module tb_keypad_multitap_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [7:0] pending_char, out_char;
  logic       out_word, out_valid, error;
  logic       out_ready = 1'b1;

  // Key matrix model: a held key drives its row while its column is driven.
  logic [3:0] key_rows = 4'b0000;
  int         key_col  = 0;
  logic       raw_mode = 1'b0;
  logic [3:0] raw_rows = 4'b0000;

  int         n_pass  = 0;
  int         n_total = 0;
  int         err_cnt = 0;
  logic [8:0] tok_q[$];

  int         tok_base, err_base;

  always #5 clk = ~clk;

  assign row_in = raw_mode ? raw_rows : (col_out[key_col] ? key_rows : 4'b0000);

  keypad_multitap_encoder #(
    .ROWS            (4),
    .COLS            (3),
    .SCAN_CYCLES     (2),
    .DEBOUNCE_CYCLES (4),
    .TAP_TIMEOUT     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row_in       (row_in),
    .col_out      (col_out),
    .pending_char (pending_char),
    .out_char     (out_char),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .error        (error)
  );

  always @(negedge clk) begin
    if (!rst && error) err_cnt++;
    if (!rst && out_valid && out_ready) tok_q.push_back({out_word, out_char});
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Hold a key until the debouncer reports it, release, then wait out release debounce.
  task automatic tap(input int r, input int c);
    bit seen;
    seen     = 1'b0;
    key_rows = 4'(1 << r);
    key_col  = c;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dut.u_scan.press_o) seen = 1'b1;
    end
    @(posedge clk); #1;
    key_rows = 4'b0000;
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    assert (seen) n_pass++;
    else $error("FAIL press_seen: observed no press required press r%0d c%0d", r, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    idle(3);
    check("rst_col", 16'(col_out), 16'h1);
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_pending", 16'(pending_char), 16'h0);
    check("rst_error", 16'(error), 16'h0);
    check("rst_char", 16'(out_char), 16'h0);
    check("rst_word", 16'(out_word), 16'h0);
    rst = 1'b0;
    idle(2);

    // Multi-tap with wrap on R1C2
    tap(1, 2); check("mt_p", 16'(pending_char), 16'h50);
    tap(1, 2); check("mt_q", 16'(pending_char), 16'h51);
    tap(1, 2); check("mt_r", 16'(pending_char), 16'h52);
    tap(1, 2); check("mt_s", 16'(pending_char), 16'h53);
    tap(1, 2); check("mt_wrap", 16'(pending_char), 16'h50);
    tok_base = tok_q.size();
    tap(3, 0);
    check("mt_ntok", 16'(tok_q.size() - tok_base), 16'd1);
    if (tok_q.size() > tok_base) check("mt_tok", 16'(tok_q[tok_base]), 16'h050);
    check("mt_idle", 16'(pending_char), 16'h0);

    // Timeout and key switch
    tap(1, 0); check("to_j", 16'(pending_char), 16'h4A);
    tap(1, 0); check("to_k", 16'(pending_char), 16'h4B);
    idle(30);
    tap(1, 0); check("to_restart", 16'(pending_char), 16'h4A);
    tap(0, 0); check("sw_a", 16'(pending_char), 16'h41);
    tok_base = tok_q.size();
    tap(3, 2);
    check("sw_ntok", 16'(tok_q.size() - tok_base), 16'd2);
    if (tok_q.size() >= tok_base + 2) begin
      check("sw_tok0", 16'(tok_q[tok_base]), 16'h041);
      check("sw_tok1", 16'(tok_q[tok_base + 1]), 16'h100);
    end
    check("sw_idle", 16'(pending_char), 16'h0);

    // Backpressure
    out_ready = 1'b0;
    tok_base  = tok_q.size();
    err_base  = err_cnt;
    tap(0, 1); tap(3, 0);
    check("bp_valid1", 16'(out_valid), 16'h1);
    check("bp_char1", 16'(out_char), 16'h44);
    tap(0, 2); tap(3, 0);
    check("bp_char2", 16'(out_char), 16'h44);
    tap(1, 1); tap(3, 0);
    check("bp_err", 16'(err_cnt - err_base), 16'd1);
    check("bp_valid3", 16'(out_valid), 16'h1);
    check("bp_char3", 16'(out_char), 16'h44);
    check("bp_pend", 16'(pending_char), 16'h4D);
    out_ready = 1'b1;
    idle(5);
    check("bp_ntok", 16'(tok_q.size() - tok_base), 16'd2);
    if (tok_q.size() >= tok_base + 2) begin
      check("bp_tok0", 16'(tok_q[tok_base]), 16'h044);
      check("bp_tok1", 16'(tok_q[tok_base + 1]), 16'h047);
    end
    check("bp_empty", 16'(out_valid), 16'h0);
    tap(3, 1); check("bp_clear", 16'(pending_char), 16'h0);

    // Rejections
    tok_base = tok_q.size();
    err_base = err_cnt;
    tap(3, 0);
    idle(3);
    check("rj_err", 16'(err_cnt - err_base), 16'd1);
    check("rj_ntok", 16'(tok_q.size() - tok_base), 16'd0);
    tap(0, 0); check("rj_a", 16'(pending_char), 16'h41);
    err_base = err_cnt;
    key_rows = 4'b0011;
    key_col  = 0;
    idle(30);
    key_rows = 4'b0000;
    idle(10);
    check("ghost_pend", 16'(pending_char), 16'h41);
    check("ghost_err", 16'(err_cnt - err_base), 16'd0);
    raw_rows = 4'b0001;
    raw_mode = 1'b1;
    idle(3);
    raw_rows = 4'b0000;
    raw_mode = 1'b0;
    idle(12);
    check("bounce_pend", 16'(pending_char), 16'h41);

    // Reset mid-tap
    tap(3, 1);
    out_ready = 1'b0;
    tap(0, 1); tap(3, 0);
    tap(0, 0); tap(0, 0);
    check("mr_b", 16'(pending_char), 16'h42);
    check("mr_valid", 16'(out_valid), 16'h1);
    rst = 1'b1;
    #2;
    check("mr_pend_now", 16'(pending_char), 16'h0);
    check("mr_valid_now", 16'(out_valid), 16'h0);
    idle(1);
    check("mr_pend", 16'(pending_char), 16'h0);
    check("mr_valid_next", 16'(out_valid), 16'h0);
    check("mr_col", 16'(col_out), 16'h1);
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
